// File: rtl/recon_pkg.sv
// Shared types and codes for the reconfiguration DMA scheduler.
// Holds the FSM encoding, request op codes and completion error codes.
package recon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StCpl   = 2'd3
    } state_e;

    localparam logic OpStore = 1'b0;  // store bitstream: DMA write channel
    localparam logic OpLoad  = 1'b1;  // load bitstream: DMA read channel

    localparam logic [3:0] ErrNone    = 4'h0;
    localparam logic [3:0] ErrZeroLen = 4'hE;
    localparam logic [3:0] ErrTimeout = 4'hF;

endpackage

// File: rtl/recon_req_queue.sv
// Synchronous FIFO for scheduler requests with an occupancy count.
// Simultaneous push and pop both take effect; DEPTH must be a power of two.
module recon_req_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrWidth = $clog2(DEPTH);
    localparam int unsigned CntWidth = $clog2(DEPTH) + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push, do_pop;

    assign full     = (count_q == DepthCnt);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

endmodule

// File: rtl/recon_dma_scheduler.sv
// Serialises bitstream store/load requests onto DMA write/read descriptor channels,
// one descriptor outstanding at a time, and reports a completion per request.
module recon_dma_scheduler
    import recon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = 34,
    parameter int unsigned DMA_DESC_LEN_WIDTH = 20,
    parameter int unsigned DMA_DESC_TAG_WIDTH = 8,
    parameter int unsigned QUEUE_DEPTH        = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          s_axis_req_op,
    input  logic [ADDR_WIDTH-1:0]         s_axis_req_addr,
    input  logic [DMA_DESC_LEN_WIDTH-1:0] s_axis_req_len,
    input  logic [7:0]                    s_axis_req_id,
    input  logic                          s_axis_req_valid,
    output logic                          s_axis_req_ready,

    output logic [ADDR_WIDTH-1:0]         m_axis_write_desc_addr,
    output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_write_desc_len,
    output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_write_desc_tag,
    output logic                          m_axis_write_desc_valid,
    input  logic                          m_axis_write_desc_ready,

    output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
    output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len,
    output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag,
    output logic                          m_axis_read_desc_valid,
    input  logic                          m_axis_read_desc_ready,

    input  logic [DMA_DESC_TAG_WIDTH-1:0] s_axis_write_desc_status_tag,
    input  logic [3:0]                    s_axis_write_desc_status_error,
    input  logic                          s_axis_write_desc_status_valid,

    input  logic [DMA_DESC_TAG_WIDTH-1:0] s_axis_read_desc_status_tag,
    input  logic [3:0]                    s_axis_read_desc_status_error,
    input  logic                          s_axis_read_desc_status_valid,

    output logic [7:0]                    m_axis_cpl_id,
    output logic                          m_axis_cpl_op,
    output logic [3:0]                    m_axis_cpl_error,
    output logic                          m_axis_cpl_valid,
    input  logic                          m_axis_cpl_ready,

    output logic                          busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int unsigned ReqWidth   = 1 + ADDR_WIDTH + DMA_DESC_LEN_WIDTH + 8;
    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(TIMEOUT_CYCLES - 1);

    state_e                          state_q, state_d;
    logic                            op_q, op_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DMA_DESC_LEN_WIDTH-1:0]   len_q, len_d;
    logic [7:0]                      id_q, id_d;
    logic [DMA_DESC_TAG_WIDTH-1:0]   tag_cnt_q, tag_cnt_d;
    logic [DMA_DESC_TAG_WIDTH-1:0]   desc_tag_q, desc_tag_d;
    logic                            wr_valid_q, wr_valid_d;
    logic                            rd_valid_q, rd_valid_d;
    logic [TimerWidth-1:0]           timer_q, timer_d;
    logic                            cpl_valid_q, cpl_valid_d;
    logic [3:0]                      cpl_error_q, cpl_error_d;

    logic [ReqWidth-1:0]             push_data, pop_data;
    logic                            pop_op;
    logic [ADDR_WIDTH-1:0]           pop_addr;
    logic [DMA_DESC_LEN_WIDTH-1:0]   pop_len;
    logic [7:0]                      pop_id;
    logic                            q_pop, q_full, q_empty;
    logic                            desc_fire, status_hit;
    logic [3:0]                      status_error;

    assign push_data = {s_axis_req_op, s_axis_req_addr, s_axis_req_len, s_axis_req_id};
    assign {pop_op, pop_addr, pop_len, pop_id} = pop_data;

    // Ready looks only at the registered count, never at this cycle's pop.
    assign s_axis_req_ready = !rst && !q_full;
    assign q_pop = (state_q == StIdle) && !q_empty;

    recon_req_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ReqWidth)
    ) u_req_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (s_axis_req_valid && s_axis_req_ready),
        .push_data (push_data),
        .pop       (q_pop),
        .pop_data  (pop_data),
        .count     (queue_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign desc_fire = (wr_valid_q && m_axis_write_desc_ready) ||
                       (rd_valid_q && m_axis_read_desc_ready);

    // Only the channel that carried the descriptor, with the issued tag, can complete it.
    always_comb begin
        status_hit   = 1'b0;
        status_error = s_axis_write_desc_status_error;
        if (op_q == OpStore) begin
            status_hit = s_axis_write_desc_status_valid &&
                         (s_axis_write_desc_status_tag == desc_tag_q);
        end else begin
            status_hit   = s_axis_read_desc_status_valid &&
                           (s_axis_read_desc_status_tag == desc_tag_q);
            status_error = s_axis_read_desc_status_error;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        tag_cnt_d   = tag_cnt_q;
        desc_tag_d  = desc_tag_q;
        wr_valid_d  = wr_valid_q;
        rd_valid_d  = rd_valid_q;
        timer_d     = timer_q;
        cpl_valid_d = cpl_valid_q;
        cpl_error_d = cpl_error_q;

        case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    op_d   = pop_op;
                    addr_d = pop_addr;
                    len_d  = pop_len;
                    id_d   = pop_id;
                    if (pop_len == '0) begin
                        cpl_valid_d = 1'b1;
                        cpl_error_d = ErrZeroLen;
                        state_d     = StCpl;
                    end else begin
                        desc_tag_d = tag_cnt_q;
                        wr_valid_d = (pop_op == OpStore);
                        rd_valid_d = (pop_op == OpLoad);
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                if (desc_fire) begin
                    wr_valid_d = 1'b0;
                    rd_valid_d = 1'b0;
                    tag_cnt_d  = tag_cnt_q + 1'b1;
                    timer_d    = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (status_hit) begin
                    cpl_valid_d = 1'b1;
                    cpl_error_d = status_error;
                    state_d     = StCpl;
                end else if (timer_q == TimerMax) begin
                    cpl_valid_d = 1'b1;
                    cpl_error_d = ErrTimeout;
                    state_d     = StCpl;
                end
            end
            StCpl: begin
                if (m_axis_cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpStore;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            tag_cnt_q   <= '0;
            desc_tag_q  <= '0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            timer_q     <= '0;
            cpl_valid_q <= 1'b0;
            cpl_error_q <= ErrNone;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            tag_cnt_q   <= tag_cnt_d;
            desc_tag_q  <= desc_tag_d;
            wr_valid_q  <= wr_valid_d;
            rd_valid_q  <= rd_valid_d;
            timer_q     <= timer_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_error_q <= cpl_error_d;
        end
    end

    assign m_axis_write_desc_addr  = addr_q;
    assign m_axis_write_desc_len   = len_q;
    assign m_axis_write_desc_tag   = desc_tag_q;
    assign m_axis_write_desc_valid = wr_valid_q;
    assign m_axis_read_desc_addr   = addr_q;
    assign m_axis_read_desc_len    = len_q;
    assign m_axis_read_desc_tag    = desc_tag_q;
    assign m_axis_read_desc_valid  = rd_valid_q;

    assign m_axis_cpl_id    = id_q;
    assign m_axis_cpl_op    = op_q;
    assign m_axis_cpl_error = cpl_error_q;
    assign m_axis_cpl_valid = cpl_valid_q;

    assign busy = (state_q != StIdle) || (queue_count != '0);

endmodule

// File: tb/tb_recon_dma_scheduler.sv
// Scoreboard bench for recon_dma_scheduler: expected descriptors and completions are
// queued as requests are driven and compared when the DUT hands them out.
module tb_recon_dma_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axis_req_op;
    logic [33:0] s_axis_req_addr;
    logic [19:0] s_axis_req_len;
    logic [7:0]  s_axis_req_id;
    logic        s_axis_req_valid;
    logic        s_axis_req_ready;
    logic [33:0] m_axis_write_desc_addr, m_axis_read_desc_addr;
    logic [19:0] m_axis_write_desc_len, m_axis_read_desc_len;
    logic [7:0]  m_axis_write_desc_tag, m_axis_read_desc_tag;
    logic        m_axis_write_desc_valid, m_axis_read_desc_valid;
    logic        m_axis_write_desc_ready, m_axis_read_desc_ready;
    logic [7:0]  s_axis_write_desc_status_tag, s_axis_read_desc_status_tag;
    logic [3:0]  s_axis_write_desc_status_error, s_axis_read_desc_status_error;
    logic        s_axis_write_desc_status_valid, s_axis_read_desc_status_valid;
    logic [7:0]  m_axis_cpl_id;
    logic        m_axis_cpl_op;
    logic [3:0]  m_axis_cpl_error;
    logic        m_axis_cpl_valid;
    logic        m_axis_cpl_ready;
    logic        busy;
    logic [2:0]  queue_count;

    typedef struct packed {
        logic        op;
        logic [33:0] addr;
        logic [19:0] len;
        logic [7:0]  tag;
    } desc_t;

    typedef struct packed {
        logic [7:0] id;
        logic       op;
        logic [3:0] err;
    } cpl_t;

    desc_t      exp_desc[$];
    cpl_t       exp_cpl[$];
    logic [7:0] exp_tag;
    int         desc_fires = 0;
    int         n_compared = 0;
    int         n_mismatched = 0;

    recon_dma_scheduler #(
        .ADDR_WIDTH         (34),
        .DMA_DESC_LEN_WIDTH (20),
        .DMA_DESC_TAG_WIDTH (8),
        .QUEUE_DEPTH        (4),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_req_op                  (s_axis_req_op),
        .s_axis_req_addr                (s_axis_req_addr),
        .s_axis_req_len                 (s_axis_req_len),
        .s_axis_req_id                  (s_axis_req_id),
        .s_axis_req_valid               (s_axis_req_valid),
        .s_axis_req_ready               (s_axis_req_ready),
        .m_axis_write_desc_addr         (m_axis_write_desc_addr),
        .m_axis_write_desc_len          (m_axis_write_desc_len),
        .m_axis_write_desc_tag          (m_axis_write_desc_tag),
        .m_axis_write_desc_valid        (m_axis_write_desc_valid),
        .m_axis_write_desc_ready        (m_axis_write_desc_ready),
        .m_axis_read_desc_addr          (m_axis_read_desc_addr),
        .m_axis_read_desc_len           (m_axis_read_desc_len),
        .m_axis_read_desc_tag           (m_axis_read_desc_tag),
        .m_axis_read_desc_valid         (m_axis_read_desc_valid),
        .m_axis_read_desc_ready         (m_axis_read_desc_ready),
        .s_axis_write_desc_status_tag   (s_axis_write_desc_status_tag),
        .s_axis_write_desc_status_error (s_axis_write_desc_status_error),
        .s_axis_write_desc_status_valid (s_axis_write_desc_status_valid),
        .s_axis_read_desc_status_tag    (s_axis_read_desc_status_tag),
        .s_axis_read_desc_status_error  (s_axis_read_desc_status_error),
        .s_axis_read_desc_status_valid  (s_axis_read_desc_status_valid),
        .m_axis_cpl_id                  (m_axis_cpl_id),
        .m_axis_cpl_op                  (m_axis_cpl_op),
        .m_axis_cpl_error               (m_axis_cpl_error),
        .m_axis_cpl_valid               (m_axis_cpl_valid),
        .m_axis_cpl_ready               (m_axis_cpl_ready),
        .busy                           (busy),
        .queue_count                    (queue_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake is matched against the head of its expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_write_desc_valid && m_axis_read_desc_valid) begin
                check_val("desc_one_channel", m_axis_read_desc_valid, 0);
            end
            if (m_axis_write_desc_valid && m_axis_write_desc_ready) begin
                desc_fires++;
                if (exp_desc.size() == 0) begin
                    check_val("wr_desc_unexpected", m_axis_write_desc_valid, 0);
                end else begin
                    check_val("wr_desc", {1'b0, m_axis_write_desc_addr, m_axis_write_desc_len,
                                          m_axis_write_desc_tag}, exp_desc.pop_front());
                end
            end
            if (m_axis_read_desc_valid && m_axis_read_desc_ready) begin
                desc_fires++;
                if (exp_desc.size() == 0) begin
                    check_val("rd_desc_unexpected", m_axis_read_desc_valid, 0);
                end else begin
                    check_val("rd_desc", {1'b1, m_axis_read_desc_addr, m_axis_read_desc_len,
                                          m_axis_read_desc_tag}, exp_desc.pop_front());
                end
            end
            if (m_axis_cpl_valid && m_axis_cpl_ready) begin
                if (exp_cpl.size() == 0) begin
                    check_val("cpl_unexpected", m_axis_cpl_valid, 0);
                end else begin
                    check_val("cpl", {m_axis_cpl_id, m_axis_cpl_op, m_axis_cpl_error},
                              exp_cpl.pop_front());
                end
            end
        end
    end

    task automatic clear_status();
        s_axis_write_desc_status_valid = 1'b0;
        s_axis_read_desc_status_valid  = 1'b0;
    endtask

    task automatic drive_status(input logic op, input logic [7:0] tag, input logic [3:0] err);
        if (op) begin
            s_axis_read_desc_status_tag   = tag;
            s_axis_read_desc_status_error = err;
            s_axis_read_desc_status_valid = 1'b1;
        end else begin
            s_axis_write_desc_status_tag   = tag;
            s_axis_write_desc_status_error = err;
            s_axis_write_desc_status_valid = 1'b1;
        end
    endtask

    task automatic send_status(input logic op, input logic [7:0] tag, input logic [3:0] err);
        drive_status(op, tag, err);
        @(posedge clk); #1;
        clear_status();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        s_axis_req_valid = 1'b0;
        m_axis_write_desc_ready = 1'b0;
        m_axis_read_desc_ready = 1'b0;
        m_axis_cpl_ready = 1'b0;
        clear_status();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", s_axis_req_ready, 0);
        check_val("rst_wr_valid", m_axis_write_desc_valid, 0);
        check_val("rst_rd_valid", m_axis_read_desc_valid, 0);
        check_val("rst_cpl_valid", m_axis_cpl_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_count", queue_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_tag = 8'd0;
    endtask

    task automatic expect_req(input logic op, input logic [33:0] addr, input logic [19:0] len,
                              input logic [7:0] id, input logic [3:0] err);
        if (len != 0) begin
            exp_desc.push_back({op, addr, len, exp_tag});
            exp_tag++;
        end
        exp_cpl.push_back({id, op, err});
    endtask

    // Returns just after the accepting edge (or a bounded give-up).
    task automatic push_req(input logic op, input logic [33:0] addr, input logic [19:0] len,
                            input logic [7:0] id);
        logic ok, rdy;
        ok = 1'b0;
        rdy = 1'b0;
        s_axis_req_op = op;
        s_axis_req_addr = addr;
        s_axis_req_len = len;
        s_axis_req_id = id;
        s_axis_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = s_axis_req_ready;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            check_val("req_accept_timeout", rdy, 1);
        end
        s_axis_req_valid = 1'b0;
    endtask

    task automatic wait_fires(input int target);
        for (int i = 0; i < 300; i++) begin
            if (desc_fires >= target) break;
            @(posedge clk); #1;
        end
        check_val("desc_fire_count", desc_fires, target);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && exp_desc.size() == 0 && exp_cpl.size() == 0) break;
        end
        check_val("idle_busy", busy, 0);
        check_val("idle_pending", exp_desc.size() + exp_cpl.size(), 0);
        @(posedge clk); #1;
    endtask

    // Stray statuses land in WAIT cycles 2 and 3; the matching one (if any) in cycle hit.
    task automatic timed_wait(input logic op, input logic [7:0] id, input int hit,
                              input logic [3:0] err, input string name);
        int         base, n;
        logic [7:0] tag;
        tag = exp_tag;
        expect_req(op, 34'h3_0000_0040, 20'h00100, id, (hit == 0) ? 4'hF : err);
        base = desc_fires;
        push_req(op, 34'h3_0000_0040, 20'h00100, id);
        wait_fires(base + 1);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            clear_status();
            if (c == 2) drive_status(op, tag ^ 8'h07, 4'h1);
            if (c == 3) drive_status(!op, tag, 4'h2);
            if (c == hit) drive_status(op, tag, err);
            @(negedge clk);
            if (m_axis_cpl_valid) break;
            n++;
            @(posedge clk); #1;
        end
        clear_status();
        check_val({name, "_wait_cycles"}, n, (hit == 0) ? 16 : hit);
        wait_idle(100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        s_axis_req_op = 1'b0;
        s_axis_req_addr = '0;
        s_axis_req_len = '0;
        s_axis_req_id = '0;
        s_axis_req_valid = 1'b0;
        s_axis_write_desc_status_tag = '0;
        s_axis_write_desc_status_error = '0;
        s_axis_read_desc_status_tag = '0;
        s_axis_read_desc_status_error = '0;
        clear_status();
        exp_tag = 8'd0;
        reset_dut();

        // Single store request: latency N+2, tag 0, clean completion.
        m_axis_write_desc_ready = 1'b1;
        m_axis_read_desc_ready = 1'b1;
        m_axis_cpl_ready = 1'b1;
        expect_req(1'b0, 34'h1_0000_0000, 20'h04000, 8'd5, 4'h0);
        base = desc_fires;
        push_req(1'b0, 34'h1_0000_0000, 20'h04000, 8'd5);
        @(negedge clk);
        check_val("lat_n1_valid", m_axis_write_desc_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("lat_n2_valid", m_axis_write_desc_valid, 1);
        check_val("lat_n2_rd_quiet", m_axis_read_desc_valid, 0);
        @(posedge clk); #1;
        wait_fires(base + 1);
        send_status(1'b0, 8'd0, 4'h0);
        wait_idle(100);

        // Five back-to-back requests against stalled engines fill the queue.
        reset_dut();
        m_axis_cpl_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_req(1'(k % 2), 34'h2_0000_0000 + 34'(k * 256), 20'(128 * (k + 1)),
                       8'(8'h10 + k), 4'(k));
        end
        base = desc_fires;
        for (int k = 0; k < 5; k++) begin
            push_req(1'(k % 2), 34'h2_0000_0000 + 34'(k * 256), 20'(128 * (k + 1)),
                     8'(8'h10 + k));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("full_count", queue_count, 4);
            check_val("full_ready", s_axis_req_ready, 0);
            check_val("stall_wr_valid", m_axis_write_desc_valid, 1);
            check_val("stall_tag", m_axis_write_desc_tag, 0);
            @(posedge clk); #1;
        end
        m_axis_write_desc_ready = 1'b1;
        m_axis_read_desc_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_fires(base + k + 1);
            send_status(1'(k % 2), 8'(k), 4'(k));
        end
        wait_idle(200);

        // Zero length: no descriptor, error E, completion held under backpressure.
        m_axis_cpl_ready = 1'b0;
        expect_req(1'b1, 34'h0_1234_5000, 20'h00000, 8'd9, 4'hE);
        push_req(1'b1, 34'h0_1234_5000, 20'h00000, 8'd9);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("zl_cpl_valid", m_axis_cpl_valid, 1);
            check_val("zl_cpl_fields", {m_axis_cpl_id, m_axis_cpl_error}, {8'd9, 4'hE});
            @(posedge clk); #1;
        end
        m_axis_cpl_ready = 1'b1;
        wait_idle(50);

        // WAIT behaviour: timeout, status on the timeout cycle, and an early match.
        reset_dut();
        m_axis_write_desc_ready = 1'b1;
        m_axis_read_desc_ready = 1'b1;
        m_axis_cpl_ready = 1'b1;
        timed_wait(1'b1, 8'h21, 0, 4'h0, "timeout");
        timed_wait(1'b0, 8'h22, 16, 4'h3, "hit_at_timeout");
        timed_wait(1'b1, 8'h23, 5, 4'h2, "early_hit");

        // Reset while waiting with two requests queued discards everything.
        exp_desc.push_back({1'b0, 34'h0_0000_1000, 20'h00010, exp_tag});
        base = desc_fires;
        push_req(1'b0, 34'h0_0000_1000, 20'h00010, 8'h31);
        push_req(1'b0, 34'h0_0000_2000, 20'h00020, 8'h32);
        push_req(1'b1, 34'h0_0000_3000, 20'h00030, 8'h33);
        @(negedge clk);
        check_val("mid_count", queue_count, 2);
        check_val("mid_busy", busy, 1);
        check_val("mid_fired", desc_fires, base + 1);
        @(posedge clk); #1;
        reset_dut();
        m_axis_write_desc_ready = 1'b1;
        m_axis_read_desc_ready = 1'b1;
        m_axis_cpl_ready = 1'b1;
        send_status(1'b0, 8'd3, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("late_status_busy", busy, 0);
            check_val("late_status_cpl", m_axis_cpl_valid, 0);
            @(posedge clk); #1;
        end
        expect_req(1'b1, 34'h0_0000_4000, 20'h00040, 8'h34, 4'h0);
        base = desc_fires;
        push_req(1'b1, 34'h0_0000_4000, 20'h00040, 8'h34);
        wait_fires(base + 1);
        send_status(1'b1, 8'd0, 4'h0);
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
